// File: rtl/bp_tile_cfg_sequencer.sv
// rtl/bp_tile_cfg_sequencer.sv - boot-time config-bus sequencer that freezes, identifies and releases every core tile
module bp_tile_cfg_sequencer #(
    parameter int cc_x_dim_p       = 2,
    parameter int cc_y_dim_p       = 2,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter logic [cfg_addr_width_p-1:0] freeze_addr_p = 16'h0002,
    parameter logic [cfg_addr_width_p-1:0] hartid_addr_p = 16'h0004,
    parameter logic [cfg_addr_width_p-1:0] coord_addr_p  = 16'h0006,
    parameter int ack_timeout_p    = 255,
    localparam int num_core_lp     = cc_x_dim_p * cc_y_dim_p,
    localparam int core_w_lp       = (num_core_lp == 1) ? 1 : $clog2(num_core_lp)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    output logic                        cfg_v_o,
    input  logic                        cfg_ready_i,
    output logic [core_w_lp-1:0]        cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ack_v_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam int tmr_w_lp = $clog2(ack_timeout_p + 1);
    localparam logic [core_w_lp-1:0] last_core_lp = core_w_lp'(num_core_lp - 1);
    localparam logic [tmr_w_lp-1:0]  last_tmr_lp  = tmr_w_lp'(ack_timeout_p - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_e;

    state_e                        state_q;
    logic [core_w_lp-1:0]          core_q;
    logic [1:0]                    reg_q;
    logic                          pass_q;
    logic [tmr_w_lp-1:0]           timer_q;
    logic                          err_q;
    logic [core_w_lp-1:0]          cfg_core_q;
    logic [cfg_addr_width_p-1:0]   cfg_addr_q;
    logic [cfg_data_width_p-1:0]   cfg_data_q;

    logic [core_w_lp-1:0]          core_d;
    logic [1:0]                    reg_d;
    logic                          pass_d;
    logic                          last_write;

    // Register address for a given pass / register slot; pass 1 only ever touches freeze.
    function automatic logic [cfg_addr_width_p-1:0] addr_of(input logic pass, input logic [1:0] rsel);
        addr_of = freeze_addr_p;
        if (!pass) begin
            case (rsel)
                2'd1:    addr_of = hartid_addr_p;
                2'd2:    addr_of = coord_addr_p;
                default: addr_of = freeze_addr_p;
            endcase
        end
    endfunction

    // Write data: freeze=1 / hart id / packed {y,x} in pass 0, freeze=0 in pass 1.
    function automatic logic [cfg_data_width_p-1:0] data_of(input logic pass,
                                                            input logic [core_w_lp-1:0] core,
                                                            input logic [1:0] rsel);
        int unsigned c_int;
        logic [7:0]  x8;
        logic [7:0]  y8;
        c_int = 32'(core);
        x8 = 8'(c_int % 32'(cc_x_dim_p));
        y8 = 8'(c_int / 32'(cc_x_dim_p));
        data_of = '0;
        if (!pass) begin
            case (rsel)
                2'd0:    data_of = cfg_data_width_p'(1);
                2'd1:    data_of = cfg_data_width_p'(core);
                2'd2:    data_of = cfg_data_width_p'({y8, x8});
                default: data_of = '0;
            endcase
        end
    endfunction

    // Position of the write that follows the current one, and whether the current one is final.
    always_comb begin
        core_d     = core_q;
        reg_d      = reg_q;
        pass_d     = pass_q;
        last_write = pass_q && (core_q == last_core_lp);
        if (pass_q) begin
            core_d = (core_q == last_core_lp) ? '0 : core_q + core_w_lp'(1);
        end else if (reg_q == 2'd2) begin
            reg_d = 2'd0;
            if (core_q == last_core_lp) begin
                core_d = '0;
                pass_d = 1'b1;
            end else begin
                core_d = core_q + core_w_lp'(1);
            end
        end else begin
            reg_d = reg_q + 2'd1;
        end
    end

    // Sequencer FSM: issue one write, wait for its ack (or time out), advance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            core_q     <= '0;
            reg_q      <= '0;
            pass_q     <= 1'b0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            cfg_core_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q    <= S_SEND;
                        core_q     <= '0;
                        reg_q      <= '0;
                        pass_q     <= 1'b0;
                        timer_q    <= '0;
                        err_q      <= 1'b0;
                        cfg_core_q <= '0;
                        cfg_addr_q <= addr_of(1'b0, 2'd0);
                        cfg_data_q <= data_of(1'b0, '0, 2'd0);
                    end else if (cfg_ack_v_i && (state_q == S_DONE)) begin
                        // IDLE is only reachable through reset, where stale acks are dropped.
                        err_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (cfg_ack_v_i) begin
                        err_q <= 1'b1;
                    end
                    if (cfg_ready_i) begin
                        state_q <= S_WAIT;
                        timer_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (cfg_ack_v_i) begin
                        if (last_write) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q    <= S_SEND;
                            core_q     <= core_d;
                            reg_q      <= reg_d;
                            pass_q     <= pass_d;
                            cfg_core_q <= core_d;
                            cfg_addr_q <= addr_of(pass_d, reg_d);
                            cfg_data_q <= data_of(pass_d, core_d, reg_d);
                        end
                    end else if (timer_q == last_tmr_lp) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        timer_q <= timer_q + tmr_w_lp'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_v_o    = (state_q == S_SEND);
    assign busy_o     = (state_q == S_SEND) || (state_q == S_WAIT);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;
    assign cfg_core_o = cfg_core_q;
    assign cfg_addr_o = cfg_addr_q;
    assign cfg_data_o = cfg_data_q;

endmodule

// File: tb/tb_bp_tile_cfg_sequencer.sv
// tb/tb_bp_tile_cfg_sequencer.sv - scoreboard bench for bp_tile_cfg_sequencer (2x2 and 3x1 arrays)
module tb_bp_tile_cfg_sequencer;

    localparam int AX = 2, AY = 2, AT = 8;
    localparam int BX = 3, BY = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          core;
        logic [15:0] addr;
        logic [63:0] data;
    } wr_t;
    typedef wr_t wr_q_t[$];

    // Reference write list built straight from the boot recipe.
    function automatic wr_q_t model(input int x, input int y);
        wr_q_t q;
        int n = x * y;
        for (int c = 0; c < n; c++) begin
            q.push_back('{c, 16'h0002, 64'd1});
            q.push_back('{c, 16'h0004, 64'(c)});
            q.push_back('{c, 16'h0006, 64'((c / x) * 256 + (c % x))});
        end
        for (int c = 0; c < n; c++) q.push_back('{c, 16'h0002, 64'd0});
        return q;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DUT A: 2x2, short ack timeout
    logic        a_reset = 1'b1, a_start = 1'b0, a_ready = 1'b1, a_ack = 1'b0;
    logic        a_v, a_busy, a_done, a_err;
    logic [1:0]  a_core;
    logic [15:0] a_addr;
    logic [63:0] a_data;

    bp_tile_cfg_sequencer #(.cc_x_dim_p(AX), .cc_y_dim_p(AY), .ack_timeout_p(AT)) dut_a (
        .clk_i(clk), .reset_i(a_reset), .start_i(a_start),
        .cfg_v_o(a_v), .cfg_ready_i(a_ready), .cfg_core_o(a_core),
        .cfg_addr_o(a_addr), .cfg_data_o(a_data), .cfg_ack_v_i(a_ack),
        .busy_o(a_busy), .done_o(a_done), .err_o(a_err)
    );

    // DUT B: 3x1, default timeout
    logic        b_reset = 1'b1, b_start = 1'b0, b_ready = 1'b1, b_ack = 1'b0;
    logic        b_v, b_busy, b_done, b_err;
    logic [1:0]  b_core;
    logic [15:0] b_addr;
    logic [63:0] b_data;

    bp_tile_cfg_sequencer #(.cc_x_dim_p(BX), .cc_y_dim_p(BY)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .start_i(b_start),
        .cfg_v_o(b_v), .cfg_ready_i(b_ready), .cfg_core_o(b_core),
        .cfg_addr_o(b_addr), .cfg_data_o(b_data), .cfg_ack_v_i(b_ack),
        .busy_o(b_busy), .done_o(b_done), .err_o(b_err)
    );

    wr_t   a_exp[$], b_exp[$];
    wr_t   a_e, b_e;
    int    a_wr_cnt = 0, b_wr_cnt = 0;
    int    a_hold_idx = -1;
    int    a_ack_dly = 0, b_ack_dly = 0;
    bit    a_bp = 1'b0, a_rand_ack = 1'b0, a_spur_req = 1'b0, a_force = 1'b0;
    bit    a_prev_stall = 1'b0;
    logic [1:0]  a_pv_core;
    logic [15:0] a_pv_addr;
    logic [63:0] a_pv_data;

    // Monitor A: pop and compare each accepted write, check payload hold under backpressure.
    always @(negedge clk) begin
        if (!a_reset && a_prev_stall) begin
            check("a_hold_v", 64'(a_v), 64'd1);
            check("a_hold_core", 64'(a_core), 64'(a_pv_core));
            check("a_hold_addr", 64'(a_addr), 64'(a_pv_addr));
            check("a_hold_data", a_data, a_pv_data);
        end
        if (!a_reset && a_v && a_ready) begin
            if (a_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_extra_write: got core %0d addr 0x%0h, expected no write", a_core, a_addr);
            end else begin
                a_e = a_exp.pop_front();
                check("a_core", 64'(a_core), 64'(a_e.core));
                check("a_addr", 64'(a_addr), 64'(a_e.addr));
                check("a_data", a_data, a_e.data);
            end
            if (a_wr_cnt != a_hold_idx) a_ack_dly = a_rand_ack ? int'($urandom_range(1, 3)) : 1;
            a_wr_cnt++;
        end
        a_prev_stall = !a_reset && a_v && !a_ready;
        a_pv_core = a_core;
        a_pv_addr = a_addr;
        a_pv_data = a_data;
    end

    // Tile model A: ack after a delay, optional spurious acks, random ready.
    always @(posedge clk) begin
        #1;
        a_ack = 1'b0;
        if (a_ack_dly > 0) begin
            a_ack_dly--;
            if (a_ack_dly == 0) a_ack = 1'b1;
        end else if (a_force) begin
            a_ack   = 1'b1;
            a_force = 1'b0;
        end else if (a_spur_req && a_v) begin
            a_ack      = 1'b1;
            a_spur_req = 1'b0;
        end
        a_ready = a_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor B
    always @(negedge clk) begin
        if (!b_reset && b_v && b_ready) begin
            if (b_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_extra_write: got core %0d addr 0x%0h, expected no write", b_core, b_addr);
            end else begin
                b_e = b_exp.pop_front();
                check("b_core", 64'(b_core), 64'(b_e.core));
                check("b_addr", 64'(b_addr), 64'(b_e.addr));
                check("b_data", b_data, b_e.data);
            end
            b_ack_dly = 1;
            b_wr_cnt++;
        end
    end

    // Tile model B: ack one cycle after each accept.
    always @(posedge clk) begin
        #1;
        b_ack = 1'b0;
        if (b_ack_dly > 0) begin
            b_ack_dly--;
            if (b_ack_dly == 0) b_ack = 1'b1;
        end
    end

    task automatic start_a();
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        check("a_first_v_latency", 64'(a_v), 64'd1);
        check("a_err_cleared_by_start", 64'(a_err), 64'd0);
    endtask

    task automatic start_b();
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        check("b_first_v_latency", 64'(b_v), 64'd1);
    endtask

    task automatic wait_done_a(input int budget);
        int k = 0;
        while (!a_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("a_done_within_budget", 64'(a_done), 64'd1);
    endtask

    task automatic wait_done_b(input int budget);
        int k = 0;
        while (!b_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("b_done_within_budget", 64'(b_done), 64'd1);
    endtask

    task automatic run_full_a(input string tag, input logic exp_err);
        wait_done_a(600);
        check({tag, "_err"}, 64'(a_err), 64'(exp_err));
        check({tag, "_busy"}, 64'(a_busy), 64'd0);
        check({tag, "_writes"}, 64'(a_wr_cnt), 64'd16);
        check({tag, "_left"}, 64'(a_exp.size()), 64'd0);
    endtask

    initial begin
        int k;
        bit saw_v;
        repeat (3) @(posedge clk);
        #1 a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        check("rst_a_v", 64'(a_v), 64'd0);
        check("rst_a_core", 64'(a_core), 64'd0);
        check("rst_a_addr", 64'(a_addr), 64'd0);
        check("rst_a_data", a_data, 64'd0);
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_a_err", 64'(a_err), 64'd0);
        check("rst_b_v", 64'(b_v), 64'd0);
        check("rst_b_done", 64'(b_done), 64'd0);

        // Spurious ack in IDLE, then a clean 2x2 run with immediate acks.
        a_force = 1'b1;
        repeat (3) @(posedge clk);
        a_exp = model(AX, AY); a_wr_cnt = 0;
        start_a();
        run_full_a("plain", 1'b0);

        // Random backpressure and random ack delays.
        a_exp = model(AX, AY); a_wr_cnt = 0; a_bp = 1'b1; a_rand_ack = 1'b1;
        start_a();
        run_full_a("bp", 1'b0);

        // Spurious ack during SEND: error flagged, sequence still completes.
        a_exp = model(AX, AY); a_wr_cnt = 0; a_rand_ack = 1'b0;
        start_a();
        repeat (5) @(posedge clk);
        a_spur_req = 1'b1;
        run_full_a("spur", 1'b1);
        check("spur_fired", 64'(a_spur_req), 64'd0);
        a_bp = 1'b0;

        // Ack withheld on write #5 (core1 hart id): timeout exactly AT cycles after accept.
        a_exp = model(AX, AY);
        while (a_exp.size() > 5) void'(a_exp.pop_back());
        a_wr_cnt = 0; a_hold_idx = 4;
        start_a();
        k = 0;
        while (a_wr_cnt < 5 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("to_reached_write5", 64'(a_wr_cnt), 64'd5);
        for (int i = 1; i <= AT + 1; i++) begin
            @(negedge clk);
            check("to_done_timing", 64'(a_done), (i == AT + 1) ? 64'd1 : 64'd0);
        end
        check("to_err", 64'(a_err), 64'd1);
        saw_v = 1'b0;
        repeat (10) begin
            @(negedge clk);
            saw_v |= a_v;
        end
        check("to_no_more_v", 64'(saw_v), 64'd0);
        check("to_writes", 64'(a_wr_cnt), 64'd5);
        check("to_left", 64'(a_exp.size()), 64'd0);
        a_hold_idx = -1;

        // Reset during pass 1, late ack ignored, restart from core0 freeze.
        a_exp = model(AX, AY); a_wr_cnt = 0;
        start_a();
        k = 0;
        while (a_wr_cnt < 14 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("rstmid_reached_pass1", 64'(a_wr_cnt >= 14), 64'd1);
        @(posedge clk); #1 a_reset = 1'b1;
        @(posedge clk); #1 a_reset = 1'b0;
        check("rstmid_v", 64'(a_v), 64'd0);
        check("rstmid_core", 64'(a_core), 64'd0);
        check("rstmid_addr", 64'(a_addr), 64'd0);
        check("rstmid_data", a_data, 64'd0);
        check("rstmid_busy", 64'(a_busy), 64'd0);
        check("rstmid_done", 64'(a_done), 64'd0);
        check("rstmid_err", 64'(a_err), 64'd0);
        a_exp.delete();
        a_force = 1'b1;
        repeat (4) @(negedge clk);
        check("late_ack_err", 64'(a_err), 64'd0);
        check("late_ack_busy", 64'(a_busy), 64'd0);
        check("late_ack_done", 64'(a_done), 64'd0);
        check("late_ack_v", 64'(a_v), 64'd0);
        a_exp = model(AX, AY); a_wr_cnt = 0;
        start_a();
        run_full_a("after_rst", 1'b0);

        // 3x1 array, run twice (second start issued from DONE).
        for (int r = 0; r < 2; r++) begin
            b_exp = model(BX, BY); b_wr_cnt = 0;
            start_b();
            wait_done_b(400);
            check("b_err", 64'(b_err), 64'd0);
            check("b_writes", 64'(b_wr_cnt), 64'd12);
            check("b_left", 64'(b_exp.size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach its end, expected completion");
        $fatal(1);
    end

endmodule
